// File: rtl/ps2_pkg.sv
// ps2_pkg: shared PS/2 frame constants and receiver state type
package ps2_pkg;
  localparam logic [7:0] PS2_PREFIX_EXT = 8'hE0;
  localparam logic [7:0] PS2_PREFIX_BRK = 8'hF0;
  localparam int PS2_FRAME_BITS = 11;
  typedef enum logic [1:0] {IDLE, RECV, DONE} ps2_rx_state_t;
endpackage

// File: rtl/ps2_line_cond.sv
// ps2_line_cond: pin synchroniser, clock run filter, aligned data delay and fall strobe
module ps2_line_cond #(
  parameter int SYNC_STAGES = 2,
  parameter int FILTER_LEN = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic ps2_clk,
  input  logic ps2_data,
  output logic filt_clk,
  output logic data,
  output logic fall
);
  localparam int CL = SYNC_STAGES + FILTER_LEN - 1;
  localparam int DL = SYNC_STAGES + FILTER_LEN;
  logic [CL-1:0] ck_q, ck_d;
  logic [DL-1:0] dt_q, dt_d;
  logic [FILTER_LEN-1:0] win;
  logic filt_q, filt_d, prev_q;
  always_comb begin
    ck_d = CL'({ck_q, ps2_clk});
    dt_d = DL'({dt_q, ps2_data});
    win = ck_q[CL-1 -: FILTER_LEN];
    filt_d = &win ? 1'b1 : (|win ? filt_q : 1'b0);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      ck_q <= '1;
      dt_q <= '1;
      filt_q <= 1'b1;
      prev_q <= 1'b1;
    end else begin
      ck_q <= ck_d;
      dt_q <= dt_d;
      filt_q <= filt_d;
      prev_q <= filt_q;
    end
  end
  assign filt_clk = filt_q;
  assign data = dt_q[DL-1];
  assign fall = prev_q & ~filt_q;
endmodule

// File: rtl/ps2_rx_frame.sv
// ps2_rx_frame: PS/2 device-to-host frame receiver with E0/F0 prefix folding
module ps2_rx_frame
  import ps2_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int FILTER_LEN = 2,
  parameter int TIMEOUT_CYC = 50000
) (
  input  logic       Bus2IP_Clk,
  input  logic       Bus2IP_Reset,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [7:0] code,
  output logic       code_valid,
  output logic       code_break,
  output logic       code_ext,
  output logic       frame_err,
  output logic       busy
);
  localparam int TW = TIMEOUT_CYC > 1 ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [TW-1:0] TMAX = TW'(TIMEOUT_CYC - 1);
  logic fclk, din, fall, ok;
  ps2_rx_state_t state_q, state_d;
  logic [3:0] bitcnt_q, bitcnt_d;
  logic [9:0] shift_q, shift_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic ext_q, ext_d, brk_q, brk_d;
  logic [7:0] code_q, code_d;
  logic cv_q, cv_d, cb_q, cb_d, ce_q, ce_d, fe_q, fe_d;
  ps2_line_cond #(.SYNC_STAGES(SYNC_STAGES), .FILTER_LEN(FILTER_LEN)) u_cond (
    .clk(Bus2IP_Clk),
    .rst(Bus2IP_Reset),
    .ps2_clk(ps2_clk),
    .ps2_data(ps2_data),
    .filt_clk(fclk),
    .data(din),
    .fall(fall)
  );
  assign ok = (^shift_q[8:0]) & shift_q[9];
  always_comb begin
    state_d = state_q;
    bitcnt_d = bitcnt_q;
    shift_d = shift_q;
    tmo_d = '0;
    ext_d = ext_q;
    brk_d = brk_q;
    code_d = code_q;
    cb_d = cb_q;
    ce_d = ce_q;
    cv_d = 1'b0;
    fe_d = 1'b0;
    if (state_q == IDLE) begin
      bitcnt_d = '0;
      if (fall && !fclk && !din) state_d = RECV;
    end else if (state_q == RECV) begin
      if (fall) begin
        shift_d = {din, shift_q[9:1]};
        bitcnt_d = bitcnt_q + 4'd1;
        if (bitcnt_q == 4'(PS2_FRAME_BITS - 2)) state_d = DONE;
      end else if (tmo_q == TMAX) begin
        state_d = IDLE;
        fe_d = 1'b1;
        ext_d = 1'b0;
        brk_d = 1'b0;
      end else begin
        tmo_d = tmo_q + 1'b1;
      end
    end else begin
      state_d = IDLE;
      if (!ok) begin
        fe_d = 1'b1;
        ext_d = 1'b0;
        brk_d = 1'b0;
      end else if (shift_q[7:0] == PS2_PREFIX_EXT) begin
        ext_d = 1'b1;
      end else if (shift_q[7:0] == PS2_PREFIX_BRK) begin
        brk_d = 1'b1;
      end else begin
        cv_d = 1'b1;
        code_d = shift_q[7:0];
        cb_d = brk_q;
        ce_d = ext_q;
        ext_d = 1'b0;
        brk_d = 1'b0;
      end
    end
  end
  always_ff @(posedge Bus2IP_Clk) begin
    if (Bus2IP_Reset) begin
      state_q <= IDLE;
      bitcnt_q <= '0;
      shift_q <= '0;
      tmo_q <= '0;
      ext_q <= 1'b0;
      brk_q <= 1'b0;
      code_q <= '0;
      cv_q <= 1'b0;
      cb_q <= 1'b0;
      ce_q <= 1'b0;
      fe_q <= 1'b0;
    end else begin
      state_q <= state_d;
      bitcnt_q <= bitcnt_d;
      shift_q <= shift_d;
      tmo_q <= tmo_d;
      ext_q <= ext_d;
      brk_q <= brk_d;
      code_q <= code_d;
      cv_q <= cv_d;
      cb_q <= cb_d;
      ce_q <= ce_d;
      fe_q <= fe_d;
    end
  end
  assign code = code_q;
  assign code_valid = cv_q;
  assign code_break = cb_q;
  assign code_ext = ce_q;
  assign frame_err = fe_q;
  assign busy = state_q != IDLE;
endmodule

// File: tb/tb_ps2_rx_frame.sv
// tb_ps2_rx_frame: table, corner-case and randomized checks of ps2_rx_frame
module tb_ps2_rx_frame;
  localparam int TMO = 64;
  localparam int LAT = 2 + 2 + 2;
  typedef struct {
    int cyc;
    logic err;
    logic [7:0] code;
    logic brk;
    logic ext;
  } ev_t;
  typedef struct {
    logic [7:0] d;
    logic bp;
    logic bs;
    int kind;
    logic [7:0] c;
    logic b;
    logic e;
  } vec_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic ps2_clk = 1'b1;
  logic ps2_data = 1'b1;
  logic [7:0] code;
  logic code_valid, code_break, code_ext, frame_err, busy;
  int cyc = 0;
  int last_fall = 0;
  int pass_n = 0;
  int total_n = 0;
  int viol = 0;
  logic cv_p = 1'b0;
  logic fe_p = 1'b0;
  ev_t evq[$];
  ps2_rx_frame #(.SYNC_STAGES(2), .FILTER_LEN(2), .TIMEOUT_CYC(TMO)) dut (
    .Bus2IP_Clk(clk),
    .Bus2IP_Reset(rst),
    .ps2_clk(ps2_clk),
    .ps2_data(ps2_data),
    .code(code),
    .code_valid(code_valid),
    .code_break(code_break),
    .code_ext(code_ext),
    .frame_err(frame_err),
    .busy(busy)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) begin
    ev_t e;
    if (code_valid || frame_err) begin
      e.cyc = cyc;
      e.err = frame_err;
      e.code = code_valid ? code : 8'h00;
      e.brk = code_valid ? code_break : 1'b0;
      e.ext = code_valid ? code_ext : 1'b0;
      evq.push_back(e);
    end
    if ((code_valid && frame_err) || (code_valid && cv_p) || (frame_err && fe_p)) viol++;
    cv_p = code_valid;
    fe_p = frame_err;
  end
  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    total_n++;
    if (got !== exp) $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
    else pass_n++;
  endtask
  function automatic logic [10:0] frm(input logic [7:0] d, input logic bp, input logic bs);
    return {~bs, (~^d) ^ bp, d, 1'b0};
  endfunction
  function automatic vec_t mk(input logic [7:0] d, input logic bp, input logic bs, input int kind,
                              input logic [7:0] c, input logic b, input logic e);
    vec_t v;
    v.d = d; v.bp = bp; v.bs = bs; v.kind = kind; v.c = c; v.b = b; v.e = e;
    return v;
  endfunction
  task automatic send_bits(input logic [10:0] bits, input int n, input int lo, input int hi);
    for (int i = 0; i < n; i++) begin
      ps2_data = bits[i];
      repeat (hi) @(posedge clk);
      #1 ps2_clk = 1'b0;
      last_fall = cyc;
      repeat (lo) @(posedge clk);
      #1 ps2_clk = 1'b1;
    end
  endtask
  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic sample;
    @(negedge clk);
  endtask
  initial begin
    vec_t tbl[18];
    int stopc[18];
    int idx, kind_got, n_exp;
    ev_t exp_q[$];
    ev_t e;
    logic pext, pbrk;
    tbl[0]  = mk(8'h1C, 1'b0, 1'b0, 1, 8'h1C, 1'b0, 1'b0);
    tbl[1]  = mk(8'hF0, 1'b0, 1'b0, 0, 8'h00, 1'b0, 1'b0);
    tbl[2]  = mk(8'h1C, 1'b0, 1'b0, 1, 8'h1C, 1'b1, 1'b0);
    tbl[3]  = mk(8'h1C, 1'b0, 1'b0, 1, 8'h1C, 1'b0, 1'b0);
    tbl[4]  = mk(8'hE0, 1'b0, 1'b0, 0, 8'h00, 1'b0, 1'b0);
    tbl[5]  = mk(8'hF0, 1'b0, 1'b0, 0, 8'h00, 1'b0, 1'b0);
    tbl[6]  = mk(8'h75, 1'b0, 1'b0, 1, 8'h75, 1'b1, 1'b1);
    tbl[7]  = mk(8'h1C, 1'b1, 1'b0, 2, 8'h00, 1'b0, 1'b0);
    tbl[8]  = mk(8'h1C, 1'b0, 1'b0, 1, 8'h1C, 1'b0, 1'b0);
    tbl[9]  = mk(8'hE0, 1'b0, 1'b0, 0, 8'h00, 1'b0, 1'b0);
    tbl[10] = mk(8'h1C, 1'b1, 1'b0, 2, 8'h00, 1'b0, 1'b0);
    tbl[11] = mk(8'h1C, 1'b0, 1'b0, 1, 8'h1C, 1'b0, 1'b0);
    tbl[12] = mk(8'hE1, 1'b0, 1'b0, 1, 8'hE1, 1'b0, 1'b0);
    tbl[13] = mk(8'hF0, 1'b0, 1'b0, 0, 8'h00, 1'b0, 1'b0);
    tbl[14] = mk(8'hAA, 1'b0, 1'b0, 1, 8'hAA, 1'b1, 1'b0);
    tbl[15] = mk(8'hE0, 1'b0, 1'b0, 0, 8'h00, 1'b0, 1'b0);
    tbl[16] = mk(8'h5A, 1'b0, 1'b1, 2, 8'h00, 1'b0, 1'b0);
    tbl[17] = mk(8'h5A, 1'b0, 1'b0, 1, 8'h5A, 1'b0, 1'b0);
    idle(4);
    rst = 1'b0;
    idle(4);
    sample;
    chk("reset_outputs", {20'd0, code, code_valid, code_break, code_ext, frame_err}, 32'd0);
    chk("reset_busy", {31'd0, busy}, 32'd0);
    evq.delete();
    n_exp = 0;
    for (int i = 0; i < 18; i++) begin
      send_bits(frm(tbl[i].d, tbl[i].bp, tbl[i].bs), 11, 3, 3);
      stopc[i] = last_fall;
      if (tbl[i].kind != 0) n_exp++;
    end
    idle(12);
    sample;
    chk("table_event_count", evq.size(), n_exp);
    for (int i = 0; i < 18; i++) begin
      idx = -1;
      foreach (evq[j]) if (evq[j].cyc == stopc[i] + LAT) idx = j;
      kind_got = idx < 0 ? 0 : (evq[idx].err ? 2 : 1);
      chk($sformatf("table_kind[%0d]", i), kind_got, tbl[i].kind);
      if (tbl[i].kind == 1 && idx >= 0)
        chk($sformatf("table_code[%0d]", i), {22'd0, evq[idx].code, evq[idx].brk, evq[idx].ext},
            {22'd0, tbl[i].c, tbl[i].b, tbl[i].e});
    end
    chk("hold_after_strobe", {22'd0, code, code_break, code_ext}, {22'd0, 8'h5A, 1'b0, 1'b0});
    evq.delete();
    send_bits(frm(8'hE0, 1'b0, 1'b0), 11, 3, 3);
    send_bits(frm(8'h33, 1'b0, 1'b0), 5, 3, 3);
    sample;
    chk("timeout_busy_mid", {31'd0, busy}, 32'd1);
    idle(TMO + 20);
    sample;
    chk("timeout_event_count", evq.size(), 1);
    if (evq.size() > 0) begin
      chk("timeout_is_err", {31'd0, evq[0].err}, 32'd1);
      chk("timeout_latency", evq[0].cyc, last_fall + 2 + 2 + 1 + TMO);
    end
    chk("timeout_busy_after", {31'd0, busy}, 32'd0);
    send_bits(frm(8'h29, 1'b0, 1'b0), 11, 3, 3);
    idle(10);
    sample;
    chk("after_timeout_count", evq.size(), 2);
    if (evq.size() > 1)
      chk("after_timeout_code", {21'd0, evq[1].err, evq[1].code, evq[1].brk, evq[1].ext},
          {21'd0, 1'b0, 8'h29, 1'b0, 1'b0});
    evq.delete();
    ps2_data = 1'b0;
    ps2_clk = 1'b0;
    idle(1);
    ps2_clk = 1'b1;
    ps2_data = 1'b1;
    idle(10);
    sample;
    chk("glitch_busy", {31'd0, busy}, 32'd0);
    chk("glitch_events", evq.size(), 0);
    send_bits(frm(8'hF0, 1'b0, 1'b0), 11, 3, 3);
    send_bits(frm(8'h5A, 1'b0, 1'b0), 5, 3, 3);
    ps2_data = 1'b1;
    rst = 1'b1;
    idle(3);
    rst = 1'b0;
    sample;
    chk("reset_mid_busy", {31'd0, busy}, 32'd0);
    chk("reset_mid_events", evq.size(), 0);
    idle(3);
    send_bits(frm(8'h5A, 1'b0, 1'b0), 11, 3, 3);
    idle(10);
    sample;
    chk("after_reset_count", evq.size(), 1);
    if (evq.size() > 0)
      chk("after_reset_code", {21'd0, evq[0].err, evq[0].code, evq[0].brk, evq[0].ext},
          {21'd0, 1'b0, 8'h5A, 1'b0, 1'b0});
    evq.delete();
    exp_q.delete();
    pext = 1'b0;
    pbrk = 1'b0;
    idle(2);
    for (int i = 0; i < 40; i++) begin
      int r;
      logic [7:0] d;
      logic bp, bs;
      r = int'($urandom_range(3));
      d = r == 0 ? 8'hE0 : (r == 1 ? 8'hF0 : 8'($urandom_range(255)));
      bp = $urandom_range(7) == 0;
      bs = $urandom_range(15) == 0;
      send_bits(frm(d, bp, bs), 11, int'($urandom_range(2, 5)), int'($urandom_range(2, 5)));
      e.cyc = last_fall + LAT;
      e.err = 1'b0;
      e.code = 8'h00;
      e.brk = 1'b0;
      e.ext = 1'b0;
      if (bp || bs) begin
        e.err = 1'b1;
        exp_q.push_back(e);
        pext = 1'b0;
        pbrk = 1'b0;
      end else if (d == 8'hE0) pext = 1'b1;
      else if (d == 8'hF0) pbrk = 1'b1;
      else begin
        e.code = d;
        e.brk = pbrk;
        e.ext = pext;
        exp_q.push_back(e);
        pext = 1'b0;
        pbrk = 1'b0;
      end
    end
    idle(12);
    sample;
    chk("random_event_count", evq.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < evq.size(); i++) begin
      chk($sformatf("random_event[%0d]", i), {21'd0, evq[i].err, evq[i].code, evq[i].brk, evq[i].ext},
          {21'd0, exp_q[i].err, exp_q[i].code, exp_q[i].brk, exp_q[i].ext});
      chk($sformatf("random_latency[%0d]", i), evq[i].cyc, exp_q[i].cyc);
    end
    chk("strobe_exclusive_single_cycle", viol, 0);
    $display("%0d/%0d checks passed", pass_n, total_n);
    $finish;
  end
endmodule
